// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
//   ram_size_e  : access size encoding on the core request port
//   lsu_state_e : LSU control states
//   mem_beat_t  : one memory request beat (we, word address, enables, data)
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } ram_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        ERR   = 3'd5
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } mem_beat_t;

    // Byte-enable mask of an access before lane shifting; 0 flags an illegal size.
    function automatic logic [BE_W-1:0] size_mask(input ram_size_e size);
        case (size)
            BYTE:      size_mask = 4'h1;
            HALF_WORD: size_mask = 4'h3;
            WORD:      size_mask = 4'hF;
            default:   size_mask = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the LSU (purely combinational).
//   Store side: st_size_i/st_offset_i/st_wdata_i -> 8-bit enable over two words,
//               64-bit lane-shifted write data, split flag, size-legal flag.
//   Load side : ld_buf_i (two read words), ld_offset_i, ld_size_i, ld_unsigned_i
//               -> right-aligned, sign/zero-extended load result.
module lsu_align
    import lsu_pkg::*;
(
    input  ram_size_e   st_size_i,
    input  logic [1:0]  st_offset_i,
    input  logic [31:0] st_wdata_i,
    output logic [7:0]  st_be_o,
    output logic [63:0] st_wdata_o,
    output logic        st_split_o,
    output logic        st_size_ok_o,
    input  logic [63:0] ld_buf_i,
    input  logic [1:0]  ld_offset_i,
    input  ram_size_e   ld_size_i,
    input  logic        ld_unsigned_i,
    output logic [31:0] ld_rdata_o
);

    logic [3:0]  mask;
    logic [4:0]  st_sh;
    logic [4:0]  ld_sh;
    logic [31:0] ld_word;

    assign mask         = size_mask(st_size_i);
    assign st_size_ok_o = |mask;
    assign st_sh        = {st_offset_i, 3'b000};
    assign ld_sh        = {ld_offset_i, 3'b000};

    // Enables and data spill into the upper word when the access crosses a boundary.
    assign st_be_o    = {4'b0000, mask} << st_offset_i;
    assign st_wdata_o = {32'd0, st_wdata_i} << st_sh;
    assign st_split_o = |st_be_o[7:4];

    assign ld_word = 32'(ld_buf_i >> ld_sh);

    // Truncate to the access size and extend.
    always_comb begin
        case (ld_size_i)
            BYTE:      ld_rdata_o = ld_unsigned_i ? {24'd0, ld_word[7:0]}
                                                  : {{24{ld_word[7]}}, ld_word[7:0]};
            HALF_WORD: ld_rdata_o = ld_unsigned_i ? {16'd0, ld_word[15:0]}
                                                  : {{16{ld_word[15]}}, ld_word[15:0]};
            default:   ld_rdata_o = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: initiator side of the data-memory req/gnt/rvalid port.
//   Core side  : req_valid_i/req_ready_o handshake with we/addr/size/unsigned/wdata;
//                one-cycle rsp_valid_o pulse with rsp_rdata_o and rsp_err_o.
//   Memory side: mem_req_o/mem_gnt_i address phase (we/addr/be/wdata held until gnt),
//                mem_rvalid_i/mem_rdata_i completion, one beat outstanding.
// Word-crossing accesses become two beats (or an error when MISALIGNED_EN = 0).
module lsu
    import lsu_pkg::*;
#(
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  ram_size_e   req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    lsu_state_e  state_q, state_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    ram_size_e   size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] base_q, base_d;
    logic [3:0]  be_hi_q, be_hi_d;
    logic [31:0] wdata_hi_q, wdata_hi_d;
    logic        split_q, split_d;
    logic [63:0] buf_q, buf_d;
    logic        mem_req_q, mem_req_d;
    mem_beat_t   beat_q, beat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [7:0]  st_be;
    logic [63:0] st_wdata;
    logic        st_split;
    logic        st_size_ok;
    logic [63:0] ld_buf;
    logic [31:0] ld_rdata;
    logic        finish;

    // Read buffer including the word arriving this cycle, so the result is ready at finish.
    assign ld_buf = (state_q == WAIT2) ? {mem_rdata_i, buf_q[31:0]}
                                       : {buf_q[63:32], mem_rdata_i};

    lsu_align u_align (
        .st_size_i     (req_size_i),
        .st_offset_i   (req_addr_i[1:0]),
        .st_wdata_i    (req_wdata_i),
        .st_be_o       (st_be),
        .st_wdata_o    (st_wdata),
        .st_split_o    (st_split),
        .st_size_ok_o  (st_size_ok),
        .ld_buf_i      (ld_buf),
        .ld_offset_i   (off_q),
        .ld_size_i     (size_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_o    (ld_rdata)
    );

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            size_q      <= BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'd0;
            base_q      <= 32'd0;
            be_hi_q     <= 4'd0;
            wdata_hi_q  <= 32'd0;
            split_q     <= 1'b0;
            buf_q       <= 64'd0;
            mem_req_q   <= 1'b0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            base_q      <= base_d;
            be_hi_q     <= be_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            split_q     <= split_d;
            buf_q       <= buf_d;
            mem_req_q   <= mem_req_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        base_d      = base_q;
        be_hi_d     = be_hi_q;
        wdata_hi_d  = wdata_hi_q;
        split_d     = split_q;
        buf_d       = buf_q;
        mem_req_d   = mem_req_q;
        beat_d      = beat_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d       = req_we_i;
                    size_d     = req_size_i;
                    uns_d      = req_unsigned_i;
                    off_d      = req_addr_i[1:0];
                    base_d     = {req_addr_i[31:2], 2'b00};
                    be_hi_d    = st_be[7:4];
                    wdata_hi_d = st_wdata[63:32];
                    split_d    = st_split;
                    if (!st_size_ok || (st_split && !MISALIGNED_EN)) begin
                        state_d = ERR;
                    end else begin
                        state_d      = REQ1;
                        mem_req_d    = 1'b1;
                        beat_d.we    = req_we_i;
                        beat_d.addr  = {req_addr_i[31:2], 2'b00};
                        beat_d.be    = st_be[3:0];
                        beat_d.wdata = st_wdata[31:0];
                    end
                end
            end
            REQ1: begin
                if (mem_gnt_i) begin
                    state_d   = WAIT1;
                    mem_req_d = 1'b0;
                end
            end
            WAIT1: begin
                if (mem_rvalid_i) begin
                    buf_d = ld_buf;
                    if (split_q) begin
                        state_d      = REQ2;
                        mem_req_d    = 1'b1;
                        beat_d.addr  = base_q + 32'd4;
                        beat_d.be    = be_hi_q;
                        beat_d.wdata = wdata_hi_q;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            REQ2: begin
                if (mem_gnt_i) begin
                    state_d   = WAIT2;
                    mem_req_d = 1'b0;
                end
            end
            WAIT2: begin
                if (mem_rvalid_i) begin
                    buf_d  = ld_buf;
                    finish = 1'b1;
                end
            end
            ERR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? 32'd0 : ld_rdata;
        end

        ready_d = (state_d == IDLE);
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = beat_q.we;
    assign mem_addr_o  = beat_q.addr;
    assign mem_be_o    = beat_q.be;
    assign mem_wdata_o = beat_q.wdata;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit: the initiator side of the core's data-memory interface. Accepts one byte/half-word/word load or store from the execute stage and issues word-aligned requests with byte enables over a req/gnt/rvalid memory port. Accesses that cross a word boundary are split into two beats. Load data is extracted and sign- or zero-extended before it is returned to the core.

Parameters:
MISALIGNED_EN, 1, 1: split word-crossing accesses into two beats; 0: reject them with rsp_err_o

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  LSU can accept a request
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address
req_size_i  in  ram_size_e  BYTE / HALF_WORD / WORD
req_unsigned_i  in  1  zero-extend load (1), sign-extend (0)
req_wdata_i  in  32  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  extended load data (0 for stores and errors)
rsp_err_o  out  1  request rejected, valid with rsp_valid_o
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepted request this cycle
mem_we_o  out  1  write beat
mem_addr_o  out  32  word address, bits [1:0] always 0
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-aligned write data
mem_rvalid_i  in  1  beat complete; read data valid (also acks writes)
mem_rdata_i  in  32  read data word

Behaviour:
- Interface (fixed): single clock clk_i. Reset rst_ni is asynchronous and active-low.
- Reset state: state IDLE. All outputs 0 except req_ready_o = 1. Reset asserted mid-transaction drops mem_req_o immediately. Pending beats are abandoned, and a late mem_rvalid_i is ignored.
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, ERR.
- Ready and accept: req_ready_o = (state == IDLE). Accept on req_valid_i && req_ready_o. On accept, register we, size, unsigned, offset = addr[1:0], base = addr & ~3, and the shifted data/enables.
- Lane mapping: size mask 0x1/0x3/0xF shifted left by offset gives an 8-bit enable. The low nibble is beat 1, the high nibble is beat 2.
  - Write data: {32'b0, wdata} << 8*offset gives a 64-bit value. Low word is beat 1, high word is beat 2.
  - A request is split iff the high nibble is nonzero (HALF_WORD at offset 3; WORD at offset != 0).
- Illegal requests: a split request with MISALIGNED_EN = 0, or an invalid size encoding, goes IDLE->ERR. No memory traffic is issued. ERR returns to IDLE with rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0.
- IDLE->REQ1: mem_req_o = 1, mem_addr_o = base, mem_be_o / mem_wdata_o set for beat 1. Address, enables, data and we stay stable until mem_gnt_i.
- REQ1 + gnt -> WAIT1. mem_req_o deasserts in the next cycle.
- WAIT1 + rvalid: store mem_rdata_i into the low half of a 64-bit buffer. Go to REQ2 if split, else finish.
- REQ2 works the same way at base + 4. The address wraps modulo 2^32, so 0xFFFF_FFFC + 4 = 0x0000_0000. Go to WAIT2 on gnt.
- WAIT2 + rvalid: store into the high half of the buffer, then finish.
- Finish: the next cycle has rsp_valid_o = 1 for exactly one cycle and state = IDLE.
  - Because state is IDLE in the response cycle, a new request may be accepted there (back-to-back).
- Load result: (buffer >> 8*offset), truncated to size. For BYTE/HALF_WORD, extend from bit 7/15 unless unsigned. WORD is passed through unchanged.
- Minimum latency from accept (cycle 0): mem_req_o in cycle 1; with gnt in cycle 1 and rvalid in cycle 2, rsp_valid_o in cycle 3. A split access adds 2 cycles.
- mem_gnt_i and mem_rvalid_i are ignored outside REQx/WAITx. Only one outstanding beat at a time. rsp_rdata_o and rsp_err_o are 0 whenever rsp_valid_o = 0.

Decomposition:
- types package: reuse ram_size_e; add lsu_state_e.
- Sub-module lsu_align (combinational): from size/offset/wdata produces the 8-bit enable, 64-bit shifted write data and split flag. From buffer/offset/size/unsigned produces the extended load result.
- The lsu top holds the FSM and registers.

Test Plan:
- Aligned word store: addr 0x100, data 0xDEADBEEF, gnt immediate, rvalid +1 -> one beat at 0x100 with be 0xF, wdata 0xDEADBEEF. rsp_valid_o in cycle 3 with rdata 0, err 0.
- Signed byte load: addr 0x103, mem word 0x80FF_0000 -> be 0x8; rsp_rdata_o = 0xFFFF_FF80. Repeat with unsigned -> 0x0000_0080.
- Split half-word store: addr 0x203, data 0xABCD -> beat 1 at 0x200, be 0x8, wdata 0xCD00_0000. Beat 2 at 0x204, be 0x1, wdata 0x0000_00AB. Exactly one response.
- Split word load: addr 0x0FE, words 0x1122_3344 @0x0FC and 0x5566_7788 @0x100 -> rsp_rdata_o = 0x7788_1122. Also check address wrap: addr 0xFFFF_FFFD, second beat at 0x0000_0000.
- MISALIGNED_EN = 0: word load at 0x101 -> no mem_req_o; rsp_valid_o with err 1 two cycles after accept. Back-to-back aligned load in the response cycle is accepted.
- Gnt stall of 3 cycles: address, enables and data held stable throughout. Assert rst_ni = 0 during WAIT1 -> mem_req_o and rsp_valid_o 0 at once; rvalid after release ignored; req_ready_o = 1.
